// File: rtl/fp_mult_result_buf.sv
// Result buffer behind a pipelined FP multiplier: an in-order circular FIFO of
// {z, status, id} with upstream back-pressure, sticky status flags and an overflow flag.
module fp_mult_result_buf #(
    parameter int sig_width    = 23,
    parameter int exp_width    = 8,
    parameter int id_width     = 8,
    parameter int depth        = 4,
    parameter int census_width = 3
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [sig_width+exp_width:0]       z,
    input  logic [7:0]                         status,
    input  logic [id_width-1:0]                arrive_id,
    input  logic                               push_out_n,
    input  logic [census_width-1:0]            pipe_census,
    output logic                               accept_n,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [sig_width+exp_width:0]       out_z,
    output logic [7:0]                         out_status,
    output logic [id_width-1:0]                out_id,
    output logic [$clog2(depth):0]             count,
    output logic [7:0]                         flags,
    input  logic                               clr_flags,
    output logic                               ovf_err,
    output logic                               idle
);

    localparam int ptr_w  = $clog2(depth);
    localparam int cnt_w  = ptr_w + 1;
    localparam int word_w = sig_width + exp_width + 1;
    localparam logic [cnt_w-1:0] full_cnt = cnt_w'(depth);

    logic [word_w-1:0]   mem_z      [depth];
    logic [7:0]          mem_status [depth];
    logic [id_width-1:0] mem_id     [depth];

    logic [ptr_w-1:0] wr_ptr;
    logic [ptr_w-1:0] rd_ptr;
    logic             push;
    logic             pop;

    assign out_valid = (count != '0);
    assign pop       = out_valid & out_ready;
    // A pop in the same cycle frees a slot, so a full buffer still accepts.
    assign accept_n  = (count == full_cnt) & ~pop;
    assign push      = ~push_out_n & ~accept_n;
    assign idle      = (count == '0) & (pipe_census == '0);

    assign out_z      = mem_z[rd_ptr];
    assign out_status = mem_status[rd_ptr];
    assign out_id     = mem_id[rd_ptr];

    // NOTE: entry storage has no reset; count and pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_z[wr_ptr]      <= z;
            mem_status[wr_ptr] <= status;
            mem_id[wr_ptr]     <= arrive_id;
        end
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            flags   <= '0;
            ovf_err <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + ptr_w'(1);
            if (pop)
                rd_ptr <= rd_ptr + ptr_w'(1);
            if (push && !pop)
                count <= count + cnt_w'(1);
            else if (pop && !push)
                count <= count - cnt_w'(1);
            flags   <= (clr_flags ? 8'h00 : flags) | (push ? status : 8'h00);
            // Dropped results are only reported, never stored.
            ovf_err <= ovf_err | (~push_out_n & accept_n);
        end
    end

endmodule
